dual_port_mem_ctrl: RTL and testbench

DUAL_PORT_MEM_CTRL -- requirements
Module: dual_port_mem_ctrl

---
 rtl/dual_port_mem_ctrl_if.sv | 34 +++
 rtl/dual_port_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dual_port_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_mem_ctrl_if.sv
// Bus bundle for dual_port_mem_ctrl: port A fetch, port B load/store and the MMIO master side.
// slave is the controller's view, master is the requester/MMIO-target view.
interface dual_port_mem_ctrl_if;
  logic [31:0] AddressA;
  logic [31:0] ExcData;
  logic [31:0] ReadDataA;

  logic        ReqB;
  logic        WeB;
  logic [2:0]  SizeB;
  logic [31:0] AddressB;
  logic [31:0] WriteData;
  logic        ReadyB;
  logic        ValidB;
  logic [31:0] ReadDataB;
  logic        ErrB;

  logic        MmioReq;
  logic        MmioWe;
  logic [31:0] MmioAddr;
  logic [31:0] MmioWData;
  logic [31:0] MmioRData;
  logic        MmioAck;

  modport slave (
    input  AddressA, ExcData, ReqB, WeB, SizeB, AddressB, WriteData, MmioRData, MmioAck,
    output ReadDataA, ReadyB, ValidB, ReadDataB, ErrB, MmioReq, MmioWe, MmioAddr, MmioWData
  );

  modport master (
    output AddressA, ExcData, ReqB, WeB, SizeB, AddressB, WriteData, MmioRData, MmioAck,
    input  ReadDataA, ReadyB, ValidB, ReadDataB, ErrB, MmioReq, MmioWe, MmioAddr, MmioWData
  );
endinterface

// File: rtl/dual_port_mem_ctrl.sv
// Dual-port RAM controller: port A is a read-only fetch pipeline with an exception-handler overlay,
// port B is a single-outstanding load/store port that also reaches an MMIO window with a timeout.
module dual_port_mem_ctrl #(
  parameter int unsigned ADDR_BITS    = 14,
  parameter int unsigned READ_LAT     = 1,
  parameter logic [15:0] MMIO_HI      = 16'hFFFF,
  parameter logic [15:0] EXC_HI       = 16'h1C09,
  parameter int unsigned MMIO_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  dual_port_mem_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned TW    = $clog2(MMIO_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, MMIO_WAIT, RESP} state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      size_q;
  logic [1:0]      lane_q;
  logic [1:0]      wait_q;
  logic [TW-1:0]   tmo_q;
  logic            valid_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            use_ram_q;
  logic            mmio_req_q;
  logic            mmio_we_q;
  logic [31:0]     mmio_addr_q;
  logic [31:0]     mmio_wdata_q;

  logic            ready;
  logic            accept;
  logic            size_ok;
  logic            misaligned;
  logic            is_mmio;
  logic            bad;
  logic            ram_wr;
  logic            ram_rd;
  logic [3:0]      be;
  logic [31:0]     wr_word;
  logic [ADDR_BITS-1:0] idx_a;
  logic [ADDR_BITS-1:0] idx_b;
  logic [31:0]     ram_a_word;
  logic [31:0]     ram_b_word;
  logic [31:0]     ext_b;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  logic            exc_sel_q;
  logic [31:0]     exc_q;
  logic [31:0]     a_word;
  logic            unused_addr;

  assign unused_addr = ^{bus.AddressA, bus.AddressB};

  // Port B request decode, evaluated on the live bus so side effects can happen on the accept edge.
  assign ready  = (state_q == IDLE) && !reset;
  assign accept = bus.ReqB && ready;
  assign idx_a  = bus.AddressA[ADDR_BITS+1:2];
  assign idx_b  = bus.AddressB[ADDR_BITS+1:2];

  always_comb begin
    size_ok = 1'b0;
    case (bus.SizeB)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
      default:                                size_ok = 1'b0;
    endcase
  end

  assign misaligned = ((bus.SizeB[1:0] == 2'b01) && bus.AddressB[0]) ||
                      ((bus.SizeB[1:0] == 2'b10) && (bus.AddressB[1:0] != 2'b00));
  assign is_mmio    = (bus.AddressB[31:16] == MMIO_HI);
  assign bad        = !size_ok || misaligned || (is_mmio && (bus.SizeB != 3'b010));
  assign ram_wr     = accept && bus.WeB && !bad && !is_mmio;
  assign ram_rd     = accept && !bus.WeB && !bad && !is_mmio;

  always_comb begin
    be      = 4'b0000;
    wr_word = bus.WriteData;
    case (bus.SizeB[1:0])
      2'b00: begin
        be[bus.AddressB[1:0]] = 1'b1;
        wr_word               = {4{bus.WriteData[7:0]}};
      end
      2'b01: begin
        be      = bus.AddressB[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.WriteData[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // One byte-wide RAM per lane; both read registers use old data when port B writes the same word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_a_q;
    logic [7:0] rd_b_q;

    always_ff @(posedge clk) begin
      if (ram_wr && be[gi]) begin
        mem[idx_b] <= wr_word[8*gi +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_a_q <= 8'h00;
      end else begin
        rd_a_q <= mem[idx_a];
      end
    end

    always_ff @(posedge clk) begin
      if (ram_rd) begin
        rd_b_q <= mem[idx_b];
      end
    end

    assign ram_a_word[8*gi +: 8] = rd_a_q;
    assign ram_b_word[8*gi +: 8] = rd_b_q;
  end

  // Port A: first stage is the RAM read plus the exception-window overlay captured alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_sel_q <= 1'b0;
      exc_q     <= 32'h0;
    end else begin
      exc_sel_q <= (bus.AddressA[31:16] == EXC_HI);
      exc_q     <= bus.ExcData;
    end
  end

  assign a_word = exc_sel_q ? exc_q : ram_a_word;

  if (READ_LAT == 1) begin : g_a_direct
    assign bus.ReadDataA = a_word;
  end else begin : g_a_pipe
    logic [31:0] pipe_q [READ_LAT-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < READ_LAT - 1; i++) begin
          pipe_q[i] <= 32'h0;
        end
      end else begin
        pipe_q[0] <= a_word;
        for (int i = 1; i < READ_LAT - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign bus.ReadDataA = pipe_q[READ_LAT-2];
  end

  // Load extraction from the held port-B read word, using the size/lane captured on accept.
  always_comb begin
    byte_v = ram_b_word[7:0];
    case (lane_q)
      2'd0: byte_v = ram_b_word[7:0];
      2'd1: byte_v = ram_b_word[15:8];
      2'd2: byte_v = ram_b_word[23:16];
      2'd3: byte_v = ram_b_word[31:24];
      default: byte_v = ram_b_word[7:0];
    endcase
    half_v = lane_q[1] ? ram_b_word[31:16] : ram_b_word[15:0];
    case (size_q)
      3'b000:  ext_b = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_b = {{16{half_v[15]}}, half_v};
      3'b100:  ext_b = {24'h0, byte_v};
      3'b101:  ext_b = {16'h0, half_v};
      default: ext_b = ram_b_word;
    endcase
  end

  // use_ram_q selects the live extraction only from RESP of a RAM load until the next accept,
  // at which point the shown value is frozen into rdata_q so ReadDataB holds across MEM_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      use_ram_q  <= 1'b0;
      mmio_req_q <= 1'b0;
      mmio_we_q  <= 1'b0;
      tmo_q      <= '0;
      wait_q     <= 2'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rdata_q   <= ext_b;
            use_ram_q <= 1'b0;
            we_q      <= bus.WeB;
            size_q    <= bus.SizeB;
            lane_q    <= bus.AddressB[1:0];
            if (bad) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else if (is_mmio) begin
              state_q      <= MMIO_WAIT;
              mmio_req_q   <= 1'b1;
              mmio_we_q    <= bus.WeB;
              mmio_addr_q  <= bus.AddressB;
              mmio_wdata_q <= bus.WriteData;
              tmo_q        <= '0;
            end else if (READ_LAT == 1) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
              if (bus.WeB) begin
                rdata_q <= 32'h0;
              end else begin
                use_ram_q <= 1'b1;
              end
            end else begin
              state_q <= MEM_WAIT;
              wait_q  <= 2'd0;
            end
          end
        end
        MEM_WAIT: begin
          if (wait_q == 2'(READ_LAT - 2)) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            if (we_q) begin
              rdata_q <= 32'h0;
            end else begin
              use_ram_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        MMIO_WAIT: begin
          if (bus.MmioAck) begin
            mmio_req_q <= 1'b0;
            state_q    <= RESP;
            valid_q    <= 1'b1;
            err_q      <= 1'b0;
            rdata_q    <= mmio_we_q ? 32'h0 : bus.MmioRData;
          end else if (tmo_q == TW'(MMIO_TIMEOUT - 1)) begin
            mmio_req_q <= 1'b0;
            state_q    <= RESP;
            valid_q    <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= 32'h0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ReadyB    = ready;
  assign bus.ValidB    = valid_q;
  assign bus.ErrB      = err_q;
  assign bus.ReadDataB = use_ram_q ? ext_b : rdata_q;
  assign bus.MmioReq   = mmio_req_q;
  assign bus.MmioWe    = mmio_we_q;
  assign bus.MmioAddr  = mmio_addr_q;
  assign bus.MmioWData = mmio_wdata_q;
endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Directed bench for dual_port_mem_ctrl with READ_LAT=2; each scenario task checks its own results.
module tb_dual_port_mem_ctrl;
  localparam int LAT = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails = 0;

  dual_port_mem_ctrl_if bus ();

  dual_port_mem_ctrl #(
    .ADDR_BITS(10), .READ_LAT(LAT), .MMIO_HI(16'hFFFF), .EXC_HI(16'h1C09), .MMIO_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.ReadyB === 1'b1) ok = 1'b1;
      else tick();
    end
    bus.ReqB = 1'b1; bus.WeB = we; bus.SizeB = size; bus.AddressB = addr; bus.WriteData = wdata;
    tick();
    bus.ReqB = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err);
    logic ok;
    lat = -1; rdata = 'x; err = 1'bx;
    start_req(we, size, addr, wdata, ok);
    if (ok) begin
      for (int i = 1; i <= 40; i++) begin
        if (bus.ValidB === 1'b1) begin
          lat = i; rdata = bus.ReadDataB; err = bus.ErrB;
          break;
        end
        tick();
      end
    end
    $display("txn we=%0b size=%03b addr=%08h wdata=%08h -> lat=%0d err=%0b rdata=%08h",
             we, size, addr, wdata, lat, err, rdata);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.ReadyB !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", bus.ReadyB); end
    checks++; if (bus.ValidB !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.ValidB); end
    checks++; if (bus.ErrB !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", bus.ErrB); end
    checks++; if (bus.ReadDataB !== 32'h0) begin fails++; $display("FAIL rst_rdb: got %h want 0", bus.ReadDataB); end
    checks++; if (bus.ReadDataA !== 32'h0) begin fails++; $display("FAIL rst_rda: got %h want 0", bus.ReadDataA); end
    checks++; if (bus.MmioReq !== 1'b0) begin fails++; $display("FAIL rst_mreq: got %b want 0", bus.MmioReq); end
    checks++; if (bus.MmioWe !== 1'b0) begin fails++; $display("FAIL rst_mwe: got %b want 0", bus.MmioWe); end
    reset = 1'b0;
    #1;
    checks++; if (bus.ReadyB !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", bus.ReadyB); end
  endtask

  task automatic test_word_sub();
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 3'b010, 32'h40, 32'h11223344, lat, d, e);
    checks++; if (lat !== LAT) begin fails++; $display("FAIL sw_lat: got %0d want %0d", lat, LAT); end
    checks++; if (e !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL sw_resp: got err=%b data=%h want 0/0", e, d); end
    do_req(1'b0, 3'b000, 32'h41, 32'h0, lat, d, e);
    checks++; if (lat !== LAT) begin fails++; $display("FAIL lb41_lat: got %0d want %0d", lat, LAT); end
    checks++; if (d !== 32'h00000033 || e !== 1'b0) begin fails++; $display("FAIL lb41: got %h err=%b want 00000033", d, e); end
    do_req(1'b0, 3'b001, 32'h42, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00001122) begin fails++; $display("FAIL lh42: got %h want 00001122", d); end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, d, e);
    checks++; if (d !== 32'h11223344) begin fails++; $display("FAIL lw40: got %h want 11223344", d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e; logic ok;
    do_req(1'b0, 3'b100, 32'h40, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00000044) begin fails++; $display("FAIL lbu40: got %h want 00000044", d); end
    start_req(1'b0, 3'b101, 32'h40, 32'h0, ok);
    checks++; if (bus.ReadyB !== 1'b0 || bus.ValidB !== 1'b0) begin fails++; $display("FAIL busy: got ready=%b valid=%b want 0/0", bus.ReadyB, bus.ValidB); end
    checks++; if (bus.ReadDataB !== 32'h00000044) begin fails++; $display("FAIL hold: got %h want 00000044", bus.ReadDataB); end
    tick();
    checks++; if (bus.ValidB !== 1'b1 || bus.ReadDataB !== 32'h00003344) begin fails++; $display("FAIL lhu40: got valid=%b %h want 1 00003344", bus.ValidB, bus.ReadDataB); end
    tick();
    checks++; if (bus.ValidB !== 1'b0 || bus.ReadDataB !== 32'h00003344) begin fails++; $display("FAIL post_hold: got valid=%b %h want 0 00003344", bus.ValidB, bus.ReadDataB); end
  endtask

  task automatic test_sign_ext();
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 3'b000, 32'h03, 32'h12345680, lat, d, e);
    do_req(1'b0, 3'b000, 32'h03, 32'h0, lat, d, e);
    checks++; if (d !== 32'hFFFFFF80) begin fails++; $display("FAIL lb03: got %h want FFFFFF80", d); end
    do_req(1'b0, 3'b100, 32'h03, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00000080) begin fails++; $display("FAIL lbu03: got %h want 00000080", d); end
    do_req(1'b1, 3'b010, 32'h04, 32'h0, lat, d, e);
    do_req(1'b1, 3'b000, 32'h05, 32'hAAAAAA7F, lat, d, e);
    do_req(1'b1, 3'b001, 32'h06, 32'hAAAA8001, lat, d, e);
    do_req(1'b0, 3'b001, 32'h06, 32'h0, lat, d, e);
    checks++; if (d !== 32'hFFFF8001) begin fails++; $display("FAIL lh06: got %h want FFFF8001", d); end
    do_req(1'b0, 3'b101, 32'h06, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00008001) begin fails++; $display("FAIL lhu06: got %h want 00008001", d); end
    do_req(1'b0, 3'b000, 32'h05, 32'h0, lat, d, e);
    checks++; if (d !== 32'h0000007F) begin fails++; $display("FAIL lb05: got %h want 0000007F", d); end
    do_req(1'b0, 3'b010, 32'h04, 32'h0, lat, d, e);
    checks++; if (d !== 32'h80017F00) begin fails++; $display("FAIL lw04: got %h want 80017F00", d); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 3'b010, 32'h100, 32'h55667788, lat, d, e);
    do_req(1'b0, 3'b010, 32'h102, 32'h0, lat, d, e);
    checks++; if (lat < 1 || e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL lw_mis: got lat=%0d err=%b %h want err=1 0", lat, e, d); end
    do_req(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, lat, d, e);
    checks++; if (lat < 1 || e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL size011: got lat=%0d err=%b %h want err=1 0", lat, e, d); end
    do_req(1'b1, 3'b001, 32'h101, 32'hFFFFFFFF, lat, d, e);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL sh_mis: got err=%b want 1", e); end
    do_req(1'b1, 3'b010, 32'h102, 32'hFFFFFFFF, lat, d, e);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL sw_mis: got err=%b want 1", e); end
    do_req(1'b0, 3'b110, 32'h100, 32'h0, lat, d, e);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL size110: got err=%b want 1", e); end
    do_req(1'b0, 3'b000, 32'hFFFF0004, 32'h0, lat, d, e);
    checks++; if (e !== 1'b1 || bus.MmioReq !== 1'b0) begin fails++; $display("FAIL mmio_lb: got err=%b mreq=%b want 1/0", e, bus.MmioReq); end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, d, e);
    checks++; if (e !== 1'b0 || d !== 32'h55667788) begin fails++; $display("FAIL ram_kept: got err=%b %h want 0 55667788", e, d); end
  endtask

  task automatic test_port_a();
    bus.AddressA = 32'h100; bus.ExcData = 32'hDEADBEEF;
    tick(); tick(); tick();
    checks++; if (bus.ReadDataA !== 32'h55667788) begin fails++; $display("FAIL fetch100: got %h want 55667788", bus.ReadDataA); end
    bus.AddressA = 32'h1C090000;
    tick();
    checks++; if (bus.ReadDataA !== 32'h55667788) begin fails++; $display("FAIL exc_early: got %h want 55667788", bus.ReadDataA); end
    tick();
    checks++; if (bus.ReadDataA !== 32'hDEADBEEF) begin fails++; $display("FAIL exc_word: got %h want DEADBEEF", bus.ReadDataA); end
  endtask

  task automatic test_read_first();
    logic ok;
    bus.AddressA = 32'h40;
    start_req(1'b1, 3'b010, 32'h40, 32'h99AABBCC, ok);
    tick();
    checks++; if (bus.ReadDataA !== 32'h11223344) begin fails++; $display("FAIL read_first_old: got %h want 11223344", bus.ReadDataA); end
    tick();
    checks++; if (bus.ReadDataA !== 32'h99AABBCC) begin fails++; $display("FAIL read_first_new: got %h want 99AABBCC", bus.ReadDataA); end
    tick();
  endtask

  task automatic test_mmio();
    int lat; logic [31:0] d; logic e; logic ok;
    do_req(1'b1, 3'b010, 32'h20, 32'h0BADF00D, lat, d, e);
    start_req(1'b0, 3'b010, 32'hFFFF0010, 32'h0, ok);
    checks++; if (bus.MmioReq !== 1'b1 || bus.MmioWe !== 1'b0 || bus.MmioAddr !== 32'hFFFF0010) begin fails++; $display("FAIL mmio_rd_req: got req=%b we=%b addr=%h want 1/0/FFFF0010", bus.MmioReq, bus.MmioWe, bus.MmioAddr); end
    tick(); tick();
    bus.MmioAck = 1'b1; bus.MmioRData = 32'h0000ABCD;
    tick();
    bus.MmioAck = 1'b0; bus.MmioRData = 32'h0;
    checks++; if (bus.ValidB !== 1'b1 || bus.ErrB !== 1'b0 || bus.ReadDataB !== 32'h0000ABCD) begin fails++; $display("FAIL mmio_rd: got valid=%b err=%b %h want 1/0/0000ABCD", bus.ValidB, bus.ErrB, bus.ReadDataB); end
    checks++; if (bus.MmioReq !== 1'b0) begin fails++; $display("FAIL mmio_drop: got %b want 0", bus.MmioReq); end
    start_req(1'b1, 3'b010, 32'hFFFF0020, 32'h12345678, ok);
    checks++; if (bus.MmioReq !== 1'b1 || bus.MmioWe !== 1'b1 || bus.MmioWData !== 32'h12345678) begin fails++; $display("FAIL mmio_wr_req: got req=%b we=%b wdata=%h want 1/1/12345678", bus.MmioReq, bus.MmioWe, bus.MmioWData); end
    bus.MmioAck = 1'b1; bus.MmioRData = 32'hFFFFFFFF;
    tick();
    bus.MmioAck = 1'b0;
    checks++; if (bus.ValidB !== 1'b1 || bus.ErrB !== 1'b0 || bus.ReadDataB !== 32'h0) begin fails++; $display("FAIL mmio_wr: got valid=%b err=%b %h want 1/0/0", bus.ValidB, bus.ErrB, bus.ReadDataB); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, d, e);
    checks++; if (d !== 32'h0BADF00D) begin fails++; $display("FAIL mmio_no_ram: got %h want 0BADF00D", d); end
  endtask

  task automatic test_timeout();
    logic ok; int lat; logic req16; int late_valid;
    lat = -1; req16 = 1'b0; late_valid = 0;
    start_req(1'b0, 3'b010, 32'hFFFF0030, 32'h0, ok);
    for (int i = 1; i <= 40; i++) begin
      if (i == TMO) req16 = bus.MmioReq;
      if (bus.ValidB === 1'b1) begin lat = i; break; end
      tick();
    end
    $display("txn mmio timeout lat=%0d err=%0b rdata=%08h", lat, bus.ErrB, bus.ReadDataB);
    checks++; if (lat !== TMO + 1) begin fails++; $display("FAIL tmo_lat: got %0d want %0d", lat, TMO + 1); end
    checks++; if (req16 !== 1'b1) begin fails++; $display("FAIL tmo_req_held: got %b want 1", req16); end
    checks++; if (bus.ErrB !== 1'b1 || bus.ReadDataB !== 32'h0 || bus.MmioReq !== 1'b0) begin fails++; $display("FAIL tmo_resp: got err=%b %h req=%b want 1/0/0", bus.ErrB, bus.ReadDataB, bus.MmioReq); end
    tick();
    bus.MmioAck = 1'b1; bus.MmioRData = 32'h5555AAAA;
    tick();
    bus.MmioAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ValidB === 1'b1) late_valid++;
      tick();
    end
    checks++; if (late_valid !== 0) begin fails++; $display("FAIL late_ack: got %0d valids want 0", late_valid); end
  endtask

  task automatic test_reset_abort();
    logic ok; int n_valid; int lat; logic [31:0] d; logic e;
    n_valid = 0;
    start_req(1'b0, 3'b010, 32'hFFFF0010, 32'h0, ok);
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.MmioReq !== 1'b0 || bus.ValidB !== 1'b0) begin fails++; $display("FAIL abort: got req=%b valid=%b want 0/0", bus.MmioReq, bus.ValidB); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ValidB === 1'b1) n_valid++;
      tick();
    end
    checks++; if (n_valid !== 0 || bus.ReadyB !== 1'b1) begin fails++; $display("FAIL abort_quiet: got valids=%0d ready=%b want 0/1", n_valid, bus.ReadyB); end
    reset = 1'b1;
    bus.ReqB = 1'b1; bus.WeB = 1'b1; bus.SizeB = 3'b010; bus.AddressB = 32'h100; bus.WriteData = 32'hFFFFFFFF;
    tick();
    bus.ReqB = 1'b0;
    reset = 1'b0;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, d, e);
    checks++; if (d !== 32'h55667788) begin fails++; $display("FAIL rst_store: got %h want 55667788", d); end
  endtask

  initial begin
    reset = 1'b1;
    bus.AddressA = 32'h0; bus.ExcData = 32'h0;
    bus.ReqB = 1'b0; bus.WeB = 1'b0; bus.SizeB = 3'b010; bus.AddressB = 32'h0; bus.WriteData = 32'h0;
    bus.MmioRData = 32'h0; bus.MmioAck = 1'b0;
    test_reset();
    test_word_sub();
    test_back_to_back();
    test_sign_ext();
    test_errors();
    test_port_a();
    test_read_first();
    test_mmio();
    test_timeout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
